// File: rtl/aes_pad_scheduler.sv
// Shares one fixed-latency AES_W pad pipeline between a path-read (0) and path-write (1) requester.
// Round-robin issue, owner tags ride alongside the pipeline, credits keep result FIFOs lossless.
module aes_pad_scheduler #(
  parameter int unsigned W            = 1,
  parameter int unsigned AESWidth     = 128,
  parameter int unsigned AESWIn_Width = 64,
  parameter int unsigned AESLatency   = 21,
  parameter int unsigned ResultDepth  = 4
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [AESWIn_Width-1:0] ReqData0,
  input  logic                    ReqValid0,
  output logic                    ReqReady0,
  input  logic [AESWIn_Width-1:0] ReqData1,
  input  logic                    ReqValid1,
  output logic                    ReqReady1,
  output logic [W*AESWidth-1:0]   PadOut0,
  output logic                    PadValid0,
  input  logic                    PadReady0,
  output logic [W*AESWidth-1:0]   PadOut1,
  output logic                    PadValid1,
  input  logic                    PadReady1,
  output logic [AESWIn_Width-1:0] AESDataIn,
  output logic                    AESDataInValid,
  input  logic [W*AESWidth-1:0]   AESDataOut,
  input  logic                    AESDataOutValid,
  output logic                    Idle,
  output logic                    ProtocolError
);

  localparam int unsigned OutW = W * AESWidth;
  localparam int unsigned CntW = $clog2(ResultDepth + 1);
  localparam int unsigned PtrW = (ResultDepth > 1) ? $clog2(ResultDepth) : 1;
  localparam logic [CntW-1:0] DepthC  = CntW'(ResultDepth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(ResultDepth - 1);

  logic [1:0][CntW-1:0]   credit_q, credit_d, cnt_q, cnt_d;
  logic [1:0][PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OutW-1:0]        mem_q [2][ResultDepth];
  logic [AESLatency-1:0]  tag_vld_q, tag_vld_d, tag_own_q, tag_own_d;
  logic                   rr_q, rr_d, active_q, err_q, err_d;
  logic [AESWIn_Width-1:0] last_q;
  logic [1:0]             elig, grant, push, pop, pad_ready;
  logic                   out_vld, out_own;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign pad_ready = {PadReady1, PadReady0};
  assign out_vld   = tag_vld_q[AESLatency-1];
  assign out_own   = tag_own_q[AESLatency-1];

  always_comb begin
    // active_q keeps grants off until the first edge after reset release
    elig[0] = active_q & ReqValid0 & (credit_q[0] != '0);
    elig[1] = active_q & ReqValid1 & (credit_q[1] != '0);
    grant   = 2'b00;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    rr_d = (elig == 2'b11) ? ~rr_q : rr_q;

    AESDataInValid = |grant;
    AESDataIn      = grant[1] ? ReqData1 : (grant[0] ? ReqData0 : last_q);

    tag_vld_d = (tag_vld_q << 1) | AESLatency'(|grant);
    tag_own_d = (tag_own_q << 1) | AESLatency'(grant[1]);

    push[0] = out_vld & ~out_own;
    push[1] = out_vld & out_own;

    credit_d = credit_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < 2; i++) begin
      pop[i]      = (cnt_q[i] != '0) & pad_ready[i];
      credit_d[i] = credit_q[i] - CntW'(grant[i]) + CntW'(pop[i]);
      cnt_d[i]    = cnt_q[i] + CntW'(push[i]) - CntW'(pop[i]);
      if (push[i]) wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
      if (pop[i])  rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
    end

    err_d = err_q | (AESDataOutValid != out_vld);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      credit_q  <= {2{DepthC}};
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tag_vld_q <= '0;
      tag_own_q <= '0;
      rr_q      <= 1'b0;
      active_q  <= 1'b0;
      err_q     <= 1'b0;
      last_q    <= '0;
    end else begin
      credit_q  <= credit_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tag_vld_q <= tag_vld_d;
      tag_own_q <= tag_own_d;
      rr_q      <= rr_d;
      active_q  <= 1'b1;
      err_q     <= err_d;
      last_q    <= AESDataIn;
    end
  end

  // Storage needs no reset: occupancy counters qualify every read.
  always_ff @(posedge Clock) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= AESDataOut;
    end
  end

  assign ReqReady0     = grant[0];
  assign ReqReady1     = grant[1];
  assign PadValid0     = (cnt_q[0] != '0);
  assign PadValid1     = (cnt_q[1] != '0);
  assign PadOut0       = mem_q[0][rd_ptr_q[0]];
  assign PadOut1       = mem_q[1][rd_ptr_q[1]];
  assign Idle          = (tag_vld_q == '0) && (cnt_q[0] == '0) && (cnt_q[1] == '0);
  assign ProtocolError = err_q;

  fifo0_overflow_a: assert property (@(posedge Clock) disable iff (!Reset)
    !(push[0] && (cnt_q[0] == DepthC) && !pop[0]));
  fifo1_overflow_a: assert property (@(posedge Clock) disable iff (!Reset)
    !(push[1] && (cnt_q[1] == DepthC) && !pop[1]));

endmodule

// File: tb/tb_aes_pad_scheduler.sv
// Bench for aes_pad_scheduler: stand-in AES_W delay line, queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_aes_pad_scheduler;
  localparam int InW   = 64;
  localparam int OutW  = 128;
  localparam int Lat   = 21;
  localparam int Depth = 4;

  logic            Clock = 1'b0, Reset = 1'b1;
  logic [InW-1:0]  ReqData0 = '0, ReqData1 = '0, AESDataIn;
  logic            ReqValid0 = 0, ReqValid1 = 0, ReqReady0, ReqReady1;
  logic [OutW-1:0] PadOut0, PadOut1, AESDataOut = '0;
  logic            PadValid0, PadValid1, PadReady0 = 0, PadReady1 = 0;
  logic            AESDataInValid, AESDataOutValid = 0, Idle, ProtocolError;

  aes_pad_scheduler #(.W(1), .AESWidth(128), .AESWIn_Width(InW), .AESLatency(Lat),
                      .ResultDepth(Depth)) dut (
    .Clock(Clock), .Reset(Reset),
    .ReqData0(ReqData0), .ReqValid0(ReqValid0), .ReqReady0(ReqReady0),
    .ReqData1(ReqData1), .ReqValid1(ReqValid1), .ReqReady1(ReqReady1),
    .PadOut0(PadOut0), .PadValid0(PadValid0), .PadReady0(PadReady0),
    .PadOut1(PadOut1), .PadValid1(PadValid1), .PadReady1(PadReady1),
    .AESDataIn(AESDataIn), .AESDataInValid(AESDataInValid),
    .AESDataOut(AESDataOut), .AESDataOutValid(AESDataOutValid),
    .Idle(Idle), .ProtocolError(ProtocolError)
  );

  always #5 Clock = ~Clock;

  typedef struct { int due; logic [OutW-1:0] data; } env_t;
  typedef struct { int due; int owner; logic [OutW-1:0] data; } fly_t;

  env_t            env_q[$];
  fly_t            m_fly[$];
  logic [OutW-1:0] m_f0[$], m_f1[$];
  int              m_rr;
  logic            m_active, m_err;
  logic [InW-1:0]  m_last;

  logic            s_rst = 1, s_rv0 = 0, s_rv1 = 0, s_pr0 = 0, s_pr1 = 0, s_inject = 0;
  logic [InW-1:0]  s_d0 = '0, s_d1 = '0;
  logic            obs_rr0, obs_rr1, obs_pv0, obs_pv1, obs_idle, obs_perr, obs_ainv;
  logic [OutW-1:0] obs_pad0;
  int              step = 0, n_checks = 0, n_fail = 0;

  // Stand-in for the AES_W transform; any fixed bijection serves.
  function automatic logic [OutW-1:0] aes_f(input logic [InW-1:0] x);
    return {~x, x ^ 64'h0123_4567_89AB_CDEF};
  endfunction

  task automatic chk(input string name, input logic [OutW-1:0] act, input logic [OutW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at step %0d: got %0h, expected %0h", name, step, act, exp);
    end
  endtask

  task automatic cycle();
    int own0, own1;
    logic e0, e1, g0, g1, due_now;
    logic [InW-1:0] exp_in;
    @(negedge Clock);
    Reset = s_rst;
    ReqValid0 = s_rv0; ReqData0 = s_d0; ReqValid1 = s_rv1; ReqData1 = s_d1;
    PadReady0 = s_pr0; PadReady1 = s_pr1;
    if (env_q.size() > 0 && env_q[0].due == step) begin
      AESDataOutValid = 1'b1;
      AESDataOut = env_q[0].data;
      void'(env_q.pop_front());
    end else begin
      AESDataOutValid = s_inject;
      AESDataOut = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    #1;
    obs_rr0 = ReqReady0; obs_rr1 = ReqReady1; obs_pv0 = PadValid0; obs_pv1 = PadValid1;
    obs_pad0 = PadOut0; obs_idle = Idle; obs_perr = ProtocolError; obs_ainv = AESDataInValid;
    if (!s_rst) begin
      m_fly.delete(); m_f0.delete(); m_f1.delete();
      m_rr = 0; m_active = 0; m_err = 0; m_last = '0;
    end
    own0 = m_f0.size();
    own1 = m_f1.size();
    foreach (m_fly[k]) if (m_fly[k].owner == 0) own0++; else own1++;
    e0 = m_active && s_rv0 && (own0 < Depth);
    e1 = m_active && s_rv1 && (own1 < Depth);
    g0 = e0 && (!e1 || m_rr == 0);
    g1 = e1 && (!e0 || m_rr == 1);
    exp_in = g1 ? s_d1 : (g0 ? s_d0 : m_last);
    chk("req_ready0", ReqReady0, g0);
    chk("req_ready1", ReqReady1, g1);
    chk("aes_in_valid", AESDataInValid, g0 || g1);
    chk("aes_in", AESDataIn, exp_in);
    chk("pad_valid0", PadValid0, m_f0.size() > 0);
    chk("pad_valid1", PadValid1, m_f1.size() > 0);
    if (m_f0.size() > 0) chk("pad_out0", PadOut0, m_f0[0]);
    if (m_f1.size() > 0) chk("pad_out1", PadOut1, m_f1[0]);
    chk("idle", Idle, m_fly.size() == 0 && m_f0.size() == 0 && m_f1.size() == 0);
    chk("protocol_error", ProtocolError, m_err);
    if (AESDataInValid) env_q.push_back('{step + Lat, aes_f(AESDataIn)});
    if (s_rst) begin
      if (g0 || g1) begin
        m_fly.push_back('{step + Lat, g1 ? 1 : 0, aes_f(exp_in)});
        m_last = exp_in;
      end
      if (e0 && e1) m_rr = 1 - m_rr;
      if (m_f0.size() > 0 && s_pr0) void'(m_f0.pop_front());
      if (m_f1.size() > 0 && s_pr1) void'(m_f1.pop_front());
      due_now = m_fly.size() > 0 && m_fly[0].due == step;
      if (due_now != AESDataOutValid) m_err = 1;
      if (due_now) begin
        if (m_fly[0].owner == 0) m_f0.push_back(m_fly[0].data);
        else m_f1.push_back(m_fly[0].data);
        void'(m_fly.pop_front());
      end
      m_active = 1;
    end
    step++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, first, cnt, cnt0, cnt1, gl[$];
    logic [OutW-1:0] pad;

    // Reset
    s_pr0 = 1; s_pr1 = 1; s_rst = 0;
    run(3);
    chk("reset_idle", obs_idle, 1);
    chk("reset_perr", obs_perr, 0);
    s_rst = 1;
    run(2);

    // Single request
    s_rv0 = 1; s_d0 = 64'h5A;
    cycle();
    chk("single_grant", obs_rr0, 1);
    t0 = step - 1; first = -1; cnt = 0; pad = '0;
    s_rv0 = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (obs_pv0) begin
        if (first < 0) first = step - 1;
        cnt++;
        pad = obs_pad0;
      end
    end
    chk("single_latency", first - t0, 22);
    chk("single_pulse", cnt, 1);
    chk("single_data", pad, 128'hFFFF_FFFF_FFFF_FFA5_0123_4567_89AB_CDB5);
    chk("single_idle", obs_idle, 1);

    // Contention: alternating grants starting at requester 0
    s_rv0 = 1; s_rv1 = 1;
    for (int k = 0; k < 8; k++) begin
      s_d0 = 64'h100 + 64'(k); s_d1 = 64'h200 + 64'(k);
      cycle();
      if (obs_rr0) gl.push_back(0);
      if (obs_rr1) gl.push_back(1);
    end
    chk("contend_count", gl.size(), 8);
    foreach (gl[k]) chk("contend_order", gl[k], k % 2);
    s_rv0 = 0; s_rv1 = 0;
    run(30);

    // Credit stall on requester 1
    s_pr1 = 0; s_rv0 = 1; s_rv1 = 1; cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 40; k++) begin
      s_d0 = {$urandom(), $urandom()}; s_d1 = {$urandom(), $urandom()};
      cycle();
      cnt0 += int'(obs_rr0); cnt1 += int'(obs_rr1);
    end
    chk("stall_grants1", cnt1, 4);
    chk("stall_rr1_low", obs_rr1, 0);
    chk("stall_req0_served", cnt0 > 4, 1);
    s_pr1 = 1;
    cycle();
    s_pr1 = 0; cnt1 = 0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      cnt1 += int'(obs_rr1);
    end
    chk("stall_one_more", cnt1, 1);
    s_rv0 = 0; s_rv1 = 0; s_pr1 = 1;
    run(40);

    // Fill FIFO0, then pop while results keep arriving
    s_pr0 = 0; s_rv0 = 1; cnt0 = 0;
    for (int k = 0; k < 34; k++) begin
      s_d0 = {$urandom(), $urandom()};
      cycle();
      cnt0 += int'(obs_rr0);
    end
    chk("full_grants0", cnt0, 4);
    chk("full_valid0", obs_pv0, 1);
    s_pr0 = 1;
    for (int k = 0; k < 40; k++) begin
      s_d0 = {$urandom(), $urandom()};
      cycle();
    end
    s_rv0 = 0;

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      s_rv0 = $urandom_range(0, 3) != 0; s_rv1 = $urandom_range(0, 2) != 0;
      s_pr0 = $urandom_range(0, 2) != 0; s_pr1 = $urandom_range(0, 3) == 0;
      s_d0 = {$urandom(), $urandom()}; s_d1 = {$urandom(), $urandom()};
      cycle();
    end

    // Drain, then inject a stray AES output
    s_rv0 = 0; s_rv1 = 0; s_pr0 = 1; s_pr1 = 1;
    for (int k = 0; k < 200 && !obs_idle; k++) cycle();
    chk("drain_idle", obs_idle, 1);
    chk("pre_inject_perr", obs_perr, 0);
    s_inject = 1;
    cycle();
    s_inject = 0;
    cycle();
    chk("perr_rise", obs_perr, 1);
    run(5);
    chk("perr_sticky", obs_perr, 1);

    // Reset mid-flight
    s_rst = 0;
    run(2);
    s_rst = 1;
    run(2);
    s_rv0 = 1; s_rv1 = 1;
    for (int k = 0; k < 10; k++) begin
      s_d0 = {$urandom(), $urandom()}; s_d1 = {$urandom(), $urandom()};
      cycle();
    end
    s_rst = 0;
    cycle();
    chk("rst_ready0", obs_rr0, 0);
    chk("rst_ready1", obs_rr1, 0);
    chk("rst_ainv", obs_ainv, 0);
    chk("rst_pv0", obs_pv0, 0);
    chk("rst_idle", obs_idle, 1);
    chk("rst_perr", obs_perr, 0);
    run(2);
    s_rst = 1; s_rv0 = 0; s_rv1 = 0; cnt = 0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      cnt += int'(obs_pv0) + int'(obs_pv1);
    end
    chk("rst_no_pads", cnt, 0);
    chk("rst_stray_perr", obs_perr, 1);
    s_pr1 = 0; s_rv1 = 1; cnt1 = 0;
    for (int k = 0; k < 12; k++) begin
      s_d1 = {$urandom(), $urandom()};
      cycle();
      cnt1 += int'(obs_rr1);
    end
    chk("rst_credits1", cnt1, 4);
    s_rv1 = 0; s_pr1 = 1;
    run(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_pad_scheduler.md
Name: aes_pad_scheduler

Overview:
- Shares one AES_W pad-generation pipeline (fixed latency, always ready, no output stall) between two requesters: port 0 = path-read decryption pads, port 1 = path-write encryption pads.
- Round-robin arbitration on issue; a tag pipeline tracks the owner of each in-flight pad.
- Per-requester result FIFOs absorb results, gated by credits so results are never dropped.
- Sits between the ORAM backend data paths and the AES_W instance; the key is wired to AES_W directly and is not handled here.

Parameters:
- W, 1, number of 128b AES lanes in AES_W; result width = W*AESWidth.
- AESWIn_Width, AESEntropy, width of the per-pad entropy (seed/IV) input.
- AESLatency, 21, cycles from AES_W input valid to output valid.
- ResultDepth, 4, entries per requester result FIFO; must be >= 1.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- ReqData0  in  AESWIn_Width  requester 0 entropy.
- ReqValid0  in  1  requester 0 request valid.
- ReqReady0  out  1  requester 0 request accepted this cycle when Valid&Ready.
- ReqData1 / ReqValid1 / ReqReady1: as above, requester 1.
- PadOut0  out  W*AESWidth  requester 0 pad.
- PadValid0  out  1  PadOut0 valid.
- PadReady0  in  1  requester 0 consumes pad on Valid&Ready.
- PadOut1 / PadValid1 / PadReady1: as above, requester 1.
- AESDataIn  out  AESWIn_Width  to AES_W DataIn.
- AESDataInValid  out  1  to AES_W DataInValid.
- AESDataOut  in  W*AESWidth  from AES_W DataOut.
- AESDataOutValid  in  1  from AES_W DataOutValid.
- Idle  out  1  no requests in flight and both FIFOs empty.
- ProtocolError  out  1  sticky; AESDataOutValid disagreed with the internal tag pipeline.

Behaviour:
- Reset (Reset=0, async):
  - Credits[i]=ResultDepth; FIFOs empty; tag pipeline all invalid; RR pointer=0.
  - ReqReady0/1=0, PadValid0/1=0, AESDataInValid=0, ProtocolError=0, Idle=1.
- Credits:
  - Credit[i] width clog2(ResultDepth+1).
  - Decrement on issue to i; increment on PadValid_i&PadReady_i; both in the same cycle leaves it unchanged.
  - Never exceeds ResultDepth and never underflows.
- Eligibility: requester i is eligible when ReqValid_i && Credit[i]!=0.
- Arbitration (combinational, one grant per cycle):
  - One eligible requester: grant it.
  - Both eligible: grant the RR pointer's requester; the pointer then moves to the other.
  - Pointer changes only on a contested grant.
  - ReqReady_i = grant_i. ReqReady is not asserted without ReqValid; ReqReady_i=0 whenever Credit[i]=0.
- Issue:
  - AESDataIn = granted ReqData; AESDataInValid = any grant. Combinational pass-through; AES_W is always ready.
  - AESDataIn holds the last granted value when idle.
- Tag pipeline:
  - AESLatency-stage shift register of {valid, owner}; stage 0 loads {grant_any, grant_1} every cycle.
  - At the output stage, tag valid marks a result arriving this cycle on AESDataOut.
- Result capture:
  - On output tag valid, AESDataOut is written into FIFO[owner] at that edge.
  - A write when the FIFO is full cannot occur (guaranteed by credits); assert in simulation.
- Results are consumed through the FIFO interface: PadValid_i = FIFO[i] not empty; PadOut_i = FIFO head; pop on PadValid_i&PadReady_i.
- Latency:
  - Request handshake at edge t -> AES result at edge t+AESLatency -> PadValid from cycle t+AESLatency+1.
  - Throughput is 1 pad/cycle aggregate.
- Ordering: per-requester FIFO order equals issue order. No ordering between requesters.
- Simultaneous write and pop on the same FIFO are allowed, including when full (pop frees the slot, write fills it) and when empty (no bypass; the data appears next cycle).
- ProtocolError: set when AESDataOutValid != output tag valid at any cycle after reset release. It is sticky until reset.
- Idle = all tag valids 0 && both FIFOs empty.
- Reset mid-operation: in-flight tags and FIFO contents are discarded. AES_W outputs arriving after reset with no tag are ignored, apart from setting ProtocolError.

Test Plan:
- Single request: ReqValid0 with Data=0x5A pulsed once, PadReady0=1 -> ReqReady0=1 that cycle; PadValid0 high exactly 22 cycles later for 1 cycle carrying AES(0x5A); Idle returns to 1.
- Contention: both ReqValid held 8 cycles, PadReady=1 -> grants alternate 0,1,0,1…; 4 pads each, in issue order.
- Credit stall: PadReady1=0, ReqValid1 held, ResultDepth=4 -> exactly 4 grants, then ReqReady1=0. Raise PadReady1 for 1 cycle -> exactly 1 further grant. ReqValid0 is still served throughout.
- Full FIFO simultaneous pop/push: FIFO0 at 4 entries with a result arriving, PadReady0=1 -> no loss; count stays 4; data order intact.
- Tag mismatch: inject AESDataOutValid=1 with no pad in flight -> ProtocolError rises next edge and stays high.
- Reset mid-flight: 10 pads in flight, Reset pulsed low -> all outputs at reset values immediately; no PadValid afterwards; Credits=4.
